// File: rtl/alu_vv_seq.sv
// Registered vector-vector ALU: per-lane add/sub/mul in one cycle, iterative restoring divide.
// Optional saturation of add/sub/mul is enabled by defining ALU_VV_SAT_EN.
module alu_vv_seq #(
  parameter int LANES = 4,
  parameter int WIDTH = 8,
  parameter int SEL_W = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [LANES-1:0][WIDTH-1:0] a,
  input  logic [LANES-1:0][WIDTH-1:0] b,
  input  logic [SEL_W-1:0]            selector,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [LANES-1:0][WIDTH-1:0] result,
  output logic [LANES-1:0]            carry_out
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic {IDLE, DIV} state_t;

  state_t                        state_q, state_d;
  logic [CNT_W-1:0]              cnt_q, cnt_d;
  logic [LANES-1:0][WIDTH-1:0]   quo_q, quo_d;
  logic [LANES-1:0][WIDTH-1:0]   rem_q, rem_d;
  logic [LANES-1:0][WIDTH-1:0]   dvs_q, dvs_d;
  logic                          out_valid_q, out_valid_d;
  logic [LANES-1:0][WIDTH-1:0]   result_q, result_d;
  logic [LANES-1:0]              flag_q, flag_d;

  logic [LANES-1:0][WIDTH:0]     sum, diff, trial, trial_sub;
  logic [LANES-1:0][2*WIDTH-1:0] prod;
  logic [LANES-1:0][WIDTH-1:0]   imm_res, quo_s, rem_s, div_res;
  logic [LANES-1:0]              imm_flag, div_flag;
  logic                          out_free, accept, load;

  logic unused_sel;
  assign unused_sel = ^selector[SEL_W-1:2];

  // Per-lane single-cycle ops and one restoring-division step on the divider registers.
  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      sum[i]  = {1'b0, a[i]} + {1'b0, b[i]};
      diff[i] = {1'b0, a[i]} - {1'b0, b[i]};
      prod[i] = {{WIDTH{1'b0}}, a[i]} * {{WIDTH{1'b0}}, b[i]};
      imm_res[i]  = '0;
      imm_flag[i] = 1'b0;
      case (selector[1:0])
        2'b00: begin
          imm_res[i]  = sum[i][WIDTH-1:0];
          imm_flag[i] = sum[i][WIDTH];
`ifdef ALU_VV_SAT_EN
          if (sum[i][WIDTH]) imm_res[i] = '1;
`endif
        end
        2'b01: begin
          imm_res[i]  = diff[i][WIDTH-1:0];
          imm_flag[i] = diff[i][WIDTH];
`ifdef ALU_VV_SAT_EN
          if (diff[i][WIDTH]) imm_res[i] = '0;
`endif
        end
        2'b10: begin
          imm_res[i]  = prod[i][WIDTH-1:0];
          imm_flag[i] = |prod[i][2*WIDTH-1:WIDTH];
`ifdef ALU_VV_SAT_EN
          if (imm_flag[i]) imm_res[i] = '1;
`endif
        end
        default: begin
          imm_res[i]  = '0;
          imm_flag[i] = 1'b0;
        end
      endcase

      trial[i]     = {rem_q[i], quo_q[i][WIDTH-1]};
      trial_sub[i] = trial[i] - {1'b0, dvs_q[i]};
      if (trial[i] >= {1'b0, dvs_q[i]}) begin
        rem_s[i] = trial_sub[i][WIDTH-1:0];
        quo_s[i] = {quo_q[i][WIDTH-2:0], 1'b1};
      end else begin
        rem_s[i] = trial[i][WIDTH-1:0];
        quo_s[i] = {quo_q[i][WIDTH-2:0], 1'b0};
      end
      div_flag[i] = (dvs_q[i] == '0);
      div_res[i]  = div_flag[i] ? {WIDTH{1'b1}} : quo_s[i];
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    quo_d       = quo_q;
    rem_d       = rem_q;
    dvs_d       = dvs_q;
    result_d    = result_q;
    flag_d      = flag_q;
    out_valid_d = out_valid_q;
    load        = 1'b0;
    out_free    = !out_valid_q || out_ready;
    in_ready    = (state_q == IDLE) && out_free;
    accept      = in_valid && in_ready;

    if (out_ready) out_valid_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept) begin
          if (selector[1:0] == 2'b11) begin
            state_d = DIV;
            cnt_d   = '0;
            quo_d   = a;
            rem_d   = '0;
            dvs_d   = b;
          end else begin
            load     = 1'b1;
            result_d = imm_res;
            flag_d   = imm_flag;
          end
        end
      end
      DIV: begin
        if (cnt_q != CNT_LAST) begin
          quo_d = quo_s;
          rem_d = rem_s;
          cnt_d = cnt_q + CNT_W'(1);
        end else if (out_free) begin
          // Final step result goes straight to the output register.
          load     = 1'b1;
          result_d = div_res;
          flag_d   = div_flag;
          state_d  = IDLE;
          cnt_d    = '0;
        end
      end
      default: state_d = IDLE;
    endcase

    if (load) out_valid_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      quo_q       <= '0;
      rem_q       <= '0;
      dvs_q       <= '0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      flag_q      <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      quo_q       <= quo_d;
      rem_q       <= rem_d;
      dvs_q       <= dvs_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      flag_q      <= flag_d;
    end
  end

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign carry_out = flag_q;

endmodule
